id_stage: RTL
=============

# id_stage

Instruction-decode stage of the RV32I pipeline, directly downstream of the fetch stage. It consumes the aligned fetch outputs `IF_PC` and `IF_Instruction` and decodes the instruction. It holds the 32x32 register file, with a WB write port and same-cycle bypass. It resolves JAL in decode, returning `ID_Jump` and `ID_PC_dest` to fetch, detects load-use hazards, and registers everything into the ID/EX pipeline register.

## Interface
- `REG_DATA_WIDTH`, 32: register and datapath width.
- `REG_ADDR_WIDTH`, 5: register index width.
- `Clk` input 1: clock, all state updates on posedge.
- `Reset_n` input 1: synchronous, active-low reset.
- `IF_PC` input 32: PC of `IF_Instruction`.
- `IF_Instruction` input 32: instruction from fetch; 0 when fetch flushes.
- `EX_PC_Branch` input 1: taken branch/JALR resolved in EX; squashes decode.
- `WB_Reg_wr` input 1: write-back enable.
- `WB_Rd` input 5: write-back destination.
- `WB_Rd_data` input 32: write-back data.
- `ID_Jump` output 1: combinational, JAL decoded this cycle.
- `ID_PC_dest` output 32: combinational, `IF_PC` + J-immediate.
- `ID_Stall` output 1: combinational load-use stall; drives fetch `IF_Stall`.
- `ID_IF_Flush` output 1: registered; kills the jump-shadow instruction; drives fetch `IF_Flush`.
- `ID_PC`, `ID_Imm`, `ID_Rs1_data`, `ID_Rs2_data` output 32 each: ID/EX register.
- `ID_Rs1`, `ID_Rs2`, `ID_Rd` output 5 each: ID/EX register.
- `ID_Opcode` output 7, `ID_Funct3` output 3, `ID_Funct7b5` output 1: ID/EX register.
- `ID_Reg_wr`, `ID_Mem_rd`, `ID_Mem_wr`, `ID_Alu_src_imm`, `ID_Branch`, `ID_Jalr` output 1 each: ID/EX control.

## Operation
- **Decode.** Opcode classes are R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Unknown opcodes decode as a bubble (all control 0).
- **Immediate generation.** I/S/B/U/J formats, sign-extended from bit 31. B and J immediates have LSB 0.
- **Register file.**
  - x0 reads 0 and writes to x0 are ignored.
  - Write on posedge when `WB_Reg_wr`.
  - Read bypass: if `WB_Reg_wr` and `WB_Rd` equals the source index and is nonzero, read data is `WB_Rd_data`.
- **JAL.** `ID_Jump` = decoded JAL && !`EX_PC_Branch` && !`jump_shadow`. JAL enters EX with `ID_Reg_wr`=1 so that EX writes PC+4 to rd.
- **Load-use hazard.** `ID_Stall` = `ID_Mem_rd` && `ID_Rd`!=0 && (`ID_Rd`==rs1, when rs1 is used || `ID_Rd`==rs2, when rs2 is used) && !`EX_PC_Branch`.
  - rs2 is used only by R, STORE and BRANCH.
  - rs1 is unused by LUI, AUIPC and JAL.
- **`jump_shadow` flop.** Set to 1 for one cycle after `ID_Jump`. It equals `ID_IF_Flush`.
- **ID/EX update priority, per posedge:**
  1. Reset: all outputs 0.
  2. `EX_PC_Branch`: bubble.
  3. `ID_Stall`: bubble; fetch holds the instruction.
  4. `jump_shadow`: bubble.
  5. Otherwise: load the decoded values.
- **Bubble definition.** All control bits 0, `ID_Rd`=0, data fields 0.

## Timing
- **Reset.** Every registered output is 0 and `jump_shadow`=0. The register file is cleared to 0 on reset (32-cycle-free; flop array).
- **Latency.** Decode to ID/EX outputs is 1 cycle. `ID_Jump`, `ID_PC_dest` and `ID_Stall` are same-cycle combinational from `IF_Instruction`/`IF_PC`.
- **Load-use.** Stall lasts exactly 1 cycle: the next cycle `ID_Mem_rd` is 0 (bubble), so `ID_Stall` drops.
- **Simultaneous events.**
  - `EX_PC_Branch` with JAL: branch wins, `ID_Jump`=0.
  - `EX_PC_Branch` with `ID_Stall`: `ID_Stall` forced 0.
  - WB write and ID read of the same register in one cycle: new data is seen.
- **Reset mid-stall or mid-shadow:** all state clears; no residual flush.

## Structure
- **Shared `RV32I_definitions` package:**
  - opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_JALR`, `OP_LUI`, `OP_AUIPC`);
  - `imm_fmt_t` enum;
  - an `id_ex_ctrl_t` struct for control bits.
- **Sub-module `regfile_2r1w`:** 32x32 flop array, 2 async read ports, 1 sync write port, x0 hardwired, write-through bypass.

## Test plan
- **Reset then ALU op.** Hold `Reset_n`=0 for 2 cycles, then `IF_Instruction`=`addi x1,x0,5` (0x00500093) with `IF_PC`=0x0.
  - Required next cycle: `ID_Imm`=5, `ID_Rd`=1, `ID_Reg_wr`=1, `ID_Alu_src_imm`=1, `ID_PC`=0.
- **WB bypass.** `WB_Reg_wr`=1, `WB_Rd`=3, `WB_Rd_data`=0xDEADBEEF in the same cycle as `add x4,x3,x0`.
  - Required: `ID_Rs1_data`=0xDEADBEEF.
  - A write to x0 leaves `ID_Rs1_data`=0 for reads of x0.
- **Load-use.** `lw x5,0(x2)` then `add x6,x5,x1`.
  - Required: `ID_Stall`=1 for exactly 1 cycle and the ID/EX bubble has `ID_Reg_wr`=0.
  - The add issues the following cycle with `ID_Rs1`=5.
- **JAL.** `jal x1,+16` at `IF_PC`=0x100.
  - Required: `ID_Jump`=1 and `ID_PC_dest`=0x110.
  - Next cycle `ID_IF_Flush`=1 and the ID/EX entry is a bubble.
- **Branch squash.** `EX_PC_Branch`=1 concurrent with a JAL in decode.
  - Required: `ID_Jump`=0, the ID/EX entry is a bubble, and `ID_IF_Flush` stays 0.
- **Negative immediate.** `beq x1,x2,-8` (0xFE208CE3).
  - Required: `ID_Imm`=0xFFFFFFF8, `ID_Branch`=1, `ID_Reg_wr`=0.

Source files
------------

// File: rtl/id_stage_pkg.sv
// ----------------------------------------------------------------------------
// RV32I_definitions
//   Shared RV32I decode definitions used by the ID stage and its register file.
//   Contents:
//     - base opcode constants (OP_*)
//     - imm_fmt_t   : immediate encoding selector
//     - id_ex_ctrl_t: control bits carried in the ID/EX pipeline register
//     - id_ex_t     : full ID/EX register payload (data + control)
//     - gen_imm()   : sign-extending immediate generator
// ----------------------------------------------------------------------------
package RV32I_definitions;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   typedef struct packed {
      logic reg_wr;
      logic mem_rd;
      logic mem_wr;
      logic alu_src_imm;
      logic branch;
      logic jalr;
   } id_ex_ctrl_t;

   localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7b5;
      id_ex_ctrl_t ctrl;
   } id_ex_t;

   // Takes instruction bits [31:7]; the opcode field never feeds an immediate.
   // All formats sign-extend from instruction bit 31; B and J have LSB 0.
   function automatic logic [31:0] gen_imm(input logic [31:7] ib, input imm_fmt_t fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{ib[31]}}, ib[31:20]};
         IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
         IMM_B:   imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
         IMM_U:   imm = {ib[31:12], 12'b0};
         IMM_J:   imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//   32-entry flop-array register file: two asynchronous read ports, one
//   synchronous write port. x0 is hardwired to zero. A write in the same
//   cycle as a read of the same (nonzero) register returns the new data.
//   Ports:
//     Clk, Reset_n            : clock, synchronous active-low reset (clears all)
//     wr_en, wr_addr, wr_data : write port (posedge)
//     rd1_addr -> rd1_data    : read port 1 (combinational)
//     rd2_addr -> rd2_data    : read port 2 (combinational)
// ----------------------------------------------------------------------------
module regfile_2r1w
   import RV32I_definitions::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd1_data,
   input  logic [ADDR_W-1:0] rd2_addr,
   output logic [DATA_W-1:0] rd2_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];

   // Writes to x0 are dropped here, so entry 0 stays at its reset value of 0.
   always_comb begin
      regs_d = regs_q;
      if (wr_en && (wr_addr != '0)) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd1_data = (rd1_addr == '0)                    ? '0      :
                     (wr_en && (wr_addr == rd1_addr))    ? wr_data :
                                                           regs_q[rd1_addr];

   assign rd2_data = (rd2_addr == '0)                    ? '0      :
                     (wr_en && (wr_addr == rd2_addr))    ? wr_data :
                                                           regs_q[rd2_addr];

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
//   RV32I instruction-decode stage. Decodes the fetched instruction, reads the
//   register file (with WB bypass), resolves JAL back to fetch, detects
//   load-use hazards and registers the result into the ID/EX register.
//   Ports:
//     Clk, Reset_n                 : clock, synchronous active-low reset
//     IF_PC, IF_Instruction        : aligned fetch outputs
//     EX_PC_Branch                 : taken branch/JALR in EX, squashes decode
//     WB_Reg_wr, WB_Rd, WB_Rd_data : register-file write port
//     ID_Jump, ID_PC_dest          : combinational JAL redirect to fetch
//     ID_Stall                     : combinational load-use stall to fetch
//     ID_IF_Flush                  : registered kill of the jump-shadow fetch
//     ID_* (remaining)             : ID/EX pipeline register outputs
// ----------------------------------------------------------------------------
module id_stage
   import RV32I_definitions::*;
#(
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [REG_DATA_WIDTH-1:0] IF_PC,
   input  logic [31:0]               IF_Instruction,
   input  logic                      EX_PC_Branch,
   input  logic                      WB_Reg_wr,
   input  logic [REG_ADDR_WIDTH-1:0] WB_Rd,
   input  logic [REG_DATA_WIDTH-1:0] WB_Rd_data,
   output logic                      ID_Jump,
   output logic [REG_DATA_WIDTH-1:0] ID_PC_dest,
   output logic                      ID_Stall,
   output logic                      ID_IF_Flush,
   output logic [REG_DATA_WIDTH-1:0] ID_PC,
   output logic [REG_DATA_WIDTH-1:0] ID_Imm,
   output logic [REG_DATA_WIDTH-1:0] ID_Rs1_data,
   output logic [REG_DATA_WIDTH-1:0] ID_Rs2_data,
   output logic [REG_ADDR_WIDTH-1:0] ID_Rs1,
   output logic [REG_ADDR_WIDTH-1:0] ID_Rs2,
   output logic [REG_ADDR_WIDTH-1:0] ID_Rd,
   output logic [6:0]                ID_Opcode,
   output logic [2:0]                ID_Funct3,
   output logic                      ID_Funct7b5,
   output logic                      ID_Reg_wr,
   output logic                      ID_Mem_rd,
   output logic                      ID_Mem_wr,
   output logic                      ID_Alu_src_imm,
   output logic                      ID_Branch,
   output logic                      ID_Jalr
);

   logic [6:0]                opcode;
   logic [REG_ADDR_WIDTH-1:0] rs1;
   logic [REG_ADDR_WIDTH-1:0] rs2;
   logic [REG_ADDR_WIDTH-1:0] rd;

   id_ex_ctrl_t dec_ctrl;
   imm_fmt_t    dec_fmt;
   logic        dec_valid;
   logic        rs1_used;
   logic        rs2_used;
   logic        is_jal;

   logic [REG_DATA_WIDTH-1:0] dec_imm;
   logic [REG_DATA_WIDTH-1:0] j_imm;
   logic [REG_DATA_WIDTH-1:0] rs1_rdata;
   logic [REG_DATA_WIDTH-1:0] rs2_rdata;

   id_ex_t id_ex_d;
   id_ex_t id_ex_q;
   logic   jump_shadow_d;
   logic   jump_shadow_q;

   assign opcode = IF_Instruction[6:0];
   assign rd     = IF_Instruction[11:7];
   assign rs1    = IF_Instruction[19:15];
   assign rs2    = IF_Instruction[24:20];

   // Opcode class decode. Anything unrecognised is not valid and becomes a
   // bubble in the ID/EX register.
   always_comb begin
      dec_ctrl  = CTRL_BUBBLE;
      dec_fmt   = IMM_NONE;
      dec_valid = 1'b1;
      rs1_used  = 1'b0;
      rs2_used  = 1'b0;
      is_jal    = 1'b0;
      case (opcode)
         OP_R: begin
            dec_ctrl.reg_wr = 1'b1;
            rs1_used        = 1'b1;
            rs2_used        = 1'b1;
         end
         OP_IMM: begin
            dec_ctrl.reg_wr      = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_fmt              = IMM_I;
            rs1_used             = 1'b1;
         end
         OP_LOAD: begin
            dec_ctrl.reg_wr      = 1'b1;
            dec_ctrl.mem_rd      = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_fmt              = IMM_I;
            rs1_used             = 1'b1;
         end
         OP_STORE: begin
            dec_ctrl.mem_wr      = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_fmt              = IMM_S;
            rs1_used             = 1'b1;
            rs2_used             = 1'b1;
         end
         OP_BRANCH: begin
            dec_ctrl.branch = 1'b1;
            dec_fmt         = IMM_B;
            rs1_used        = 1'b1;
            rs2_used        = 1'b1;
         end
         OP_JAL: begin
            // Reg_wr lets EX write the link address PC+4 into rd.
            dec_ctrl.reg_wr = 1'b1;
            dec_fmt         = IMM_J;
            is_jal          = 1'b1;
         end
         OP_JALR: begin
            dec_ctrl.reg_wr      = 1'b1;
            dec_ctrl.jalr        = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_fmt              = IMM_I;
            rs1_used             = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec_ctrl.reg_wr      = 1'b1;
            dec_ctrl.alu_src_imm = 1'b1;
            dec_fmt              = IMM_U;
         end
         default: begin
            dec_valid = 1'b0;
         end
      endcase
   end

   assign dec_imm = gen_imm(IF_Instruction[31:7], dec_fmt);
   assign j_imm   = gen_imm(IF_Instruction[31:7], IMM_J);

   // Redirect target is always presented; ID_Jump qualifies it.
   assign ID_PC_dest = IF_PC + j_imm;

   // A JAL sitting in the jump shadow is the wrong-path fetch after a taken
   // JAL and must not redirect again.
   assign ID_Jump = is_jal && !EX_PC_Branch && !jump_shadow_q;

   // Load-use: the load now in ID/EX cannot forward its data in time.
   assign ID_Stall = id_ex_q.ctrl.mem_rd && (id_ex_q.rd != '0) &&
                     ((rs1_used && (id_ex_q.rd == rs1)) ||
                      (rs2_used && (id_ex_q.rd == rs2))) &&
                     !EX_PC_Branch;

   regfile_2r1w #(
      .DATA_W (REG_DATA_WIDTH),
      .ADDR_W (REG_ADDR_WIDTH)
   ) u_regfile (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .wr_en    (WB_Reg_wr),
      .wr_addr  (WB_Rd),
      .wr_data  (WB_Rd_data),
      .rd1_addr (rs1),
      .rd1_data (rs1_rdata),
      .rd2_addr (rs2),
      .rd2_data (rs2_rdata)
   );

   // ID/EX next value: squash, stall and shadow all insert an all-zero bubble.
   always_comb begin
      id_ex_d = '0;
      if (!EX_PC_Branch && !ID_Stall && !jump_shadow_q && dec_valid) begin
         id_ex_d.pc       = IF_PC;
         id_ex_d.imm      = dec_imm;
         id_ex_d.rs1_data = rs1_rdata;
         id_ex_d.rs2_data = rs2_rdata;
         id_ex_d.rs1      = rs1;
         id_ex_d.rs2      = rs2;
         id_ex_d.rd       = rd;
         id_ex_d.opcode   = opcode;
         id_ex_d.funct3   = IF_Instruction[14:12];
         id_ex_d.funct7b5 = IF_Instruction[30];
         id_ex_d.ctrl     = dec_ctrl;
      end
   end

   assign jump_shadow_d = ID_Jump;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         id_ex_q       <= '0;
         jump_shadow_q <= 1'b0;
      end else begin
         id_ex_q       <= id_ex_d;
         jump_shadow_q <= jump_shadow_d;
      end
   end

   assign ID_IF_Flush    = jump_shadow_q;
   assign ID_PC          = id_ex_q.pc;
   assign ID_Imm         = id_ex_q.imm;
   assign ID_Rs1_data    = id_ex_q.rs1_data;
   assign ID_Rs2_data    = id_ex_q.rs2_data;
   assign ID_Rs1         = id_ex_q.rs1;
   assign ID_Rs2         = id_ex_q.rs2;
   assign ID_Rd          = id_ex_q.rd;
   assign ID_Opcode      = id_ex_q.opcode;
   assign ID_Funct3      = id_ex_q.funct3;
   assign ID_Funct7b5    = id_ex_q.funct7b5;
   assign ID_Reg_wr      = id_ex_q.ctrl.reg_wr;
   assign ID_Mem_rd      = id_ex_q.ctrl.mem_rd;
   assign ID_Mem_wr      = id_ex_q.ctrl.mem_wr;
   assign ID_Alu_src_imm = id_ex_q.ctrl.alu_src_imm;
   assign ID_Branch      = id_ex_q.ctrl.branch;
   assign ID_Jalr        = id_ex_q.ctrl.jalr;

endmodule
